packet_rd_responder: RTL and testbench

- Memory-side responder for the CPU core's packet read interface: byte address + transfer size + read enable in; zero-extended, right-justified data + ready pulse out.
- Sits between the BPF CPU core and the 32-bit-wide packet RAM.
- Performs big-endian (network order) byte, halfword and word extraction, including unaligned reads that span two RAM words.
- Bounds-checks every read against the current packet length.

---
 rtl/packet_rd_responder.sv | 158 +++++++++++++++
 tb/tb_packet_rd_responder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/packet_rd_responder.sv
// Packet-RAM read responder: big-endian byte/half/word extraction from a
// 32-bit synchronous RAM, with unaligned two-word reads and length bounds check.
module packet_rd_responder #(
  parameter int PACKET_BYTE_ADDR_WIDTH = 12,
  parameter int PACKET_ADDR_WIDTH      = PACKET_BYTE_ADDR_WIDTH - 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              rd_en,
  input  logic [PACKET_BYTE_ADDR_WIDTH-1:0] byte_addr,
  input  logic [1:0]                        transfer_sz,
  input  logic [PACKET_BYTE_ADDR_WIDTH:0]   pkt_len,
  output logic [31:0]                       resp_data,
  output logic                              resp_valid,
  output logic                              resp_oob,
  output logic                              busy,
  output logic                              ram_rd_en,
  output logic [PACKET_ADDR_WIDTH-1:0]      ram_addr,
  input  logic [31:0]                       ram_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT0, WAIT1, DONE} state_t;

  state_t                         state_reg;
  logic [31:0]                    resp_data_reg;
  logic                           resp_valid_reg;
  logic                           resp_oob_reg;
  logic                           busy_reg;
  logic [31:0]                    hi_reg;
  logic [1:0]                     offset_reg;
  logic [1:0]                     sz_reg;
  logic [PACKET_ADDR_WIDTH-1:0]   word_reg;
  logic                           span_reg;

  logic [PACKET_BYTE_ADDR_WIDTH:0] req_size;
  logic [PACKET_BYTE_ADDR_WIDTH:0] req_end;
  logic                            req_oob;
  logic                            req_span;
  logic [1:0]                      req_offset;

  assign req_offset = byte_addr[1:0];

  always_comb begin
    req_size = '0;
    case (transfer_sz)
      2'b00:   req_size = (PACKET_BYTE_ADDR_WIDTH+1)'(4);
      2'b01:   req_size = (PACKET_BYTE_ADDR_WIDTH+1)'(2);
      2'b10:   req_size = (PACKET_BYTE_ADDR_WIDTH+1)'(1);
      default: req_size = '0;
    endcase
  end

  // One extra bit keeps byte_addr+size from wrapping at the top of the address space.
  assign req_end  = {1'b0, byte_addr} + req_size;
  assign req_oob  = (transfer_sz == 2'b11) || (req_end > pkt_len);
  assign req_span = ((transfer_sz == 2'b00) && (req_offset != 2'd0)) ||
                    ((transfer_sz == 2'b01) && (req_offset == 2'd3));

  // Network-order pick from {hi, lo}: first byte is at the MSB end, shifted by the offset.
  function automatic logic [31:0] extract(input logic [63:0] c,
                                          input logic [1:0]  off,
                                          input logic [1:0]  sz);
    logic [63:0] sh;
    sh = c << {off, 3'b000};
    case (sz)
      2'b00:   extract = sh[63:32];
      2'b01:   extract = {16'h0000, sh[63:48]};
      default: extract = {24'h000000, sh[63:56]};
    endcase
  endfunction

  // RAM requests are issued combinationally so the RAM samples on the accept/WAIT0 edge.
  always_comb begin
    ram_rd_en = 1'b0;
    ram_addr  = '0;
    if (rst) begin
      case (state_reg)
        IDLE: begin
          if (rd_en && !req_oob) begin
            ram_rd_en = 1'b1;
            ram_addr  = byte_addr[PACKET_BYTE_ADDR_WIDTH-1:2];
          end
        end
        WAIT0: begin
          if (span_reg) begin
            ram_rd_en = 1'b1;
            ram_addr  = word_reg + PACKET_ADDR_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= IDLE;
      resp_data_reg  <= '0;
      resp_valid_reg <= 1'b0;
      resp_oob_reg   <= 1'b0;
      busy_reg       <= 1'b0;
      hi_reg         <= '0;
      offset_reg     <= '0;
      sz_reg         <= '0;
      word_reg       <= '0;
      span_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (rd_en) begin
            busy_reg <= 1'b1;
            if (req_oob) begin
              state_reg      <= DONE;
              resp_data_reg  <= '0;
              resp_oob_reg   <= 1'b1;
              resp_valid_reg <= 1'b1;
            end else begin
              state_reg  <= WAIT0;
              offset_reg <= req_offset;
              sz_reg     <= transfer_sz;
              word_reg   <= byte_addr[PACKET_BYTE_ADDR_WIDTH-1:2];
              span_reg   <= req_span;
            end
          end
        end
        WAIT0: begin
          hi_reg <= ram_rdata;
          if (span_reg) begin
            state_reg <= WAIT1;
          end else begin
            state_reg      <= DONE;
            resp_data_reg  <= extract({ram_rdata, 32'h0}, offset_reg, sz_reg);
            resp_oob_reg   <= 1'b0;
            resp_valid_reg <= 1'b1;
          end
        end
        WAIT1: begin
          state_reg      <= DONE;
          resp_data_reg  <= extract({hi_reg, ram_rdata}, offset_reg, sz_reg);
          resp_oob_reg   <= 1'b0;
          resp_valid_reg <= 1'b1;
        end
        DONE: begin
          state_reg      <= IDLE;
          resp_valid_reg <= 1'b0;
          busy_reg       <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign resp_data  = resp_data_reg;
  assign resp_valid = resp_valid_reg;
  assign resp_oob   = resp_oob_reg;
  assign busy       = busy_reg;

endmodule

// File: tb/tb_packet_rd_responder.sv
// Scoreboard bench for packet_rd_responder: directed reads queue expectations,
// a negedge monitor checks data, oob flag, latency and RAM access pattern.
module tb_packet_rd_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd_en = 1'b0;
  logic [11:0] byte_addr = '0;
  logic [1:0]  transfer_sz = 2'b10;
  logic [12:0] pkt_len = 13'd64;
  logic [31:0] resp_data;
  logic        resp_valid;
  logic        resp_oob;
  logic        busy;
  logic        ram_rd_en;
  logic [9:0]  ram_addr;
  logic [31:0] ram_rdata = '0;

  logic [31:0] mem [0:1023];

  typedef struct {
    logic [31:0] data;
    logic        oob;
    int          lat;
    int          nreads;
    logic [9:0]  addr0;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   reads = 0;

  packet_rd_responder dut (
    .clk         (clk),
    .rst         (rst),
    .rd_en       (rd_en),
    .byte_addr   (byte_addr),
    .transfer_sz (transfer_sz),
    .pkt_len     (pkt_len),
    .resp_data   (resp_data),
    .resp_valid  (resp_valid),
    .resp_oob    (resp_oob),
    .busy        (busy),
    .ram_rd_en   (ram_rd_en),
    .ram_addr    (ram_addr),
    .ram_rdata   (ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_rd_en) ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: tracks acceptance and RAM reads, pops the scoreboard on each response.
  always @(negedge clk) begin
    if (rst && rd_en && !busy) begin
      acc_cyc = cyc;
      reads = ram_rd_en ? 1 : 0;
      if (ram_rd_en && q.size() > 0) chk("ram_addr_first", 32'(ram_addr), 32'(q[0].addr0));
    end else if (ram_rd_en) begin
      reads++;
      if (q.size() > 0) chk("ram_addr_second", 32'(ram_addr), 32'(q[0].addr0 + 10'd1));
    end
    if (resp_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_response actual=%h required=none", resp_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        $display("resp data=%h oob=%0b lat=%0d reads=%0d", resp_data, resp_oob, cyc - acc_cyc, reads);
        chk("resp_data", resp_data, e.data);
        chk("resp_oob", 32'(resp_oob), 32'(e.oob));
        chk("latency", 32'(cyc - acc_cyc), 32'(e.lat));
        chk("ram_reads", 32'(reads), 32'(e.nreads));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the DONE cycle.
  task automatic do_req(input logic [11:0] addr, input logic [1:0] sz, input logic [12:0] len,
                        input logic [31:0] d, input logic oob, input int lat, input int nr,
                        input logic [9:0] a0, input bit keep);
    exp_t e;
    bit   seen;
    e.data = d; e.oob = oob; e.lat = lat; e.nreads = nr; e.addr0 = a0;
    q.push_back(e);
    byte_addr = addr; transfer_sz = sz; pkt_len = len; rd_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #1;
      if (resp_valid) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL timeout actual=no_resp required=resp addr=%h", addr);
    end
    if (!keep) begin
      rd_en = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[0] = 32'h11223344;
    mem[1] = 32'h55667788;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", 32'(resp_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_data", resp_data, 32'd0);
    chk("reset_ram_rd_en", 32'(ram_rd_en), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    do_req(12'd2, 2'b10, 13'd64, 32'h00000033, 1'b0, 2, 1, 10'd0, 1'b0);
    do_req(12'd3, 2'b00, 13'd64, 32'h44556677, 1'b0, 3, 2, 10'd0, 1'b0);
    do_req(12'd4, 2'b00, 13'd64, 32'h55667788, 1'b0, 2, 1, 10'd1, 1'b0);
    do_req(12'd3, 2'b01, 13'd64, 32'h00004455, 1'b0, 3, 2, 10'd0, 1'b0);
    do_req(12'd2, 2'b01, 13'd64, 32'h00003344, 1'b0, 2, 1, 10'd0, 1'b0);
    do_req(12'd7, 2'b10, 13'd64, 32'h00000088, 1'b0, 2, 1, 10'd1, 1'b0);
    do_req(12'd4, 2'b00, 13'd6,  32'h00000000, 1'b1, 1, 0, 10'd0, 1'b0);
    do_req(12'd0, 2'b11, 13'd6,  32'h00000000, 1'b1, 1, 0, 10'd0, 1'b0);
    do_req(12'd4, 2'b01, 13'd6,  32'h00005566, 1'b0, 2, 1, 10'd1, 1'b0);
    do_req(12'd6, 2'b10, 13'd6,  32'h00000000, 1'b1, 1, 0, 10'd0, 1'b0);

    // rd_en stays high across both requests.
    do_req(12'd0, 2'b10, 13'd64, 32'h00000011, 1'b0, 2, 1, 10'd0, 1'b1);
    do_req(12'd5, 2'b10, 13'd64, 32'h00000066, 1'b0, 2, 1, 10'd1, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Spanning read aborted by reset while in WAIT1: no response expected.
    byte_addr = 12'd3; transfer_sz = 2'b00; pkt_len = 13'd64; rd_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_valid", 32'(resp_valid), 32'd0);
    chk("abort_data", resp_data, 32'd0);
    chk("abort_oob", 32'(resp_oob), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ram_rd_en", 32'(ram_rd_en), 32'd0);
    chk("abort_ram_addr", 32'(ram_addr), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_req(12'd1, 2'b10, 13'd64, 32'h00000022, 1'b0, 2, 1, 10'd0, 1'b0);

    repeat (5) @(posedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
